scratchpad_arbiter: RTL and testbench

//   Shares one PE scratchpad single_port_ram between the host MMIO port (reads and writes)
//   and the PE datapath (TIA_OP_LSW / TIA_OP_SSW). Host has priority; a streak counter bounds
//   PE starvation. RAM control is registered; every access is a 3-state IDLE/ISSUE/COMPLETE

---
 rtl/scratchpad_arbiter_if.sv | 25 ++
 rtl/scratchpad_arbiter.sv | 139 +++++++++++++
 tb/tb_scratchpad_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/scratchpad_arbiter_if.sv
// MMIO host port into the PE scratchpad: independent read and write
// request channels, each with its own one-cycle acknowledge.
interface mmio_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              read_req;
    logic [ADDR_W-1:0] read_index;
    logic              read_ack;
    logic [DATA_W-1:0] read_data;
    logic              write_req;
    logic [ADDR_W-1:0] write_index;
    logic [DATA_W-1:0] write_data;
    logic              write_ack;

    modport device (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );

    modport host (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );
endinterface

// File: rtl/scratchpad_arbiter.sv
// Shares one single-port scratchpad RAM between the MMIO host and the PE
// datapath (LSW/SSW). Host wins by default; a streak counter forces a PE
// grant after MAX_HOST_STREAK consecutive host grants while the PE waits.
// Every access is IDLE -> ISSUE -> COMPLETE, so the RAM strobes are
// registered and the read data lines up with the COMPLETE cycle.
module scratchpad_arbiter #(
    parameter int DEPTH           = 1024,
    parameter int MAX_HOST_STREAK = 4,
    parameter int TIA_WORD_WIDTH  = 32,
    parameter int TIA_OP_WIDTH    = 6,
    parameter logic [TIA_OP_WIDTH-1:0] OP_LSW = 6'h10,
    parameter logic [TIA_OP_WIDTH-1:0] OP_SSW = 6'h11,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int STREAK_W = $clog2(MAX_HOST_STREAK + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    mmio_if.device                    host_interface,
    input  logic                      pe_req,
    input  logic [TIA_OP_WIDTH-1:0]   pe_op,
    input  logic [TIA_WORD_WIDTH-1:0] pe_operand_0,
    input  logic [TIA_WORD_WIDTH-1:0] pe_operand_1,
    output logic                      pe_stall,
    output logic [TIA_WORD_WIDTH-1:0] pe_result,
    output logic                      pe_result_valid,
    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    output logic [IDX_W-1:0]          ram_index,
    output logic [TIA_WORD_WIDTH-1:0] ram_write_data,
    input  logic [TIA_WORD_WIDTH-1:0] ram_read_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_HOST_RD, OWN_HOST_WR, OWN_PE} owner_t;

    state_t                state;
    owner_t                owner;
    owner_t                grant;
    logic [STREAK_W-1:0]   streak;
    logic                  pe_is_lsw;
    logic                  pe_first;
    logic [TIA_WORD_WIDTH-1:0] read_addr;
    logic [TIA_WORD_WIDTH-1:0] write_addr;
    logic                  unused_upper;

    assign read_addr  = host_interface.read_index;
    assign write_addr = host_interface.write_index;

    // Address bits above the RAM index width are deliberately ignored.
    assign unused_upper = ^{read_addr[TIA_WORD_WIDTH-1:IDX_W],
                            write_addr[TIA_WORD_WIDTH-1:IDX_W],
                            pe_operand_1[TIA_WORD_WIDTH-1:IDX_W]};

    assign pe_first = pe_req && (streak == STREAK_W'(MAX_HOST_STREAK));

    // Fixed priority (read > write > PE) unless the host streak has run out.
    always_comb begin
        grant = OWN_NONE;
        if (pe_first)                     grant = OWN_PE;
        else if (host_interface.read_req)  grant = OWN_HOST_RD;
        else if (host_interface.write_req) grant = OWN_HOST_WR;
        else if (pe_req)                  grant = OWN_PE;
    end

    // Transaction FSM: grant in IDLE, strobe RAM for one ISSUE cycle, ack in COMPLETE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            owner            <= OWN_NONE;
            streak           <= '0;
            pe_is_lsw        <= 1'b0;
            ram_read_enable  <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_index        <= '0;
            ram_write_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    owner            <= grant;
                    pe_is_lsw        <= (pe_op == OP_LSW);
                    ram_read_enable  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    ram_index        <= '0;
                    ram_write_data   <= '0;
                    case (grant)
                        OWN_HOST_RD: begin
                            ram_read_enable <= 1'b1;
                            ram_index       <= read_addr[IDX_W-1:0];
                        end
                        OWN_HOST_WR: begin
                            ram_write_enable <= 1'b1;
                            ram_index        <= write_addr[IDX_W-1:0];
                            ram_write_data   <= host_interface.write_data;
                        end
                        OWN_PE: begin
                            // Non-memory opcodes are granted but never touch the RAM.
                            if (pe_op == OP_LSW) begin
                                ram_read_enable <= 1'b1;
                                ram_index       <= pe_operand_0[IDX_W-1:0];
                            end else if (pe_op == OP_SSW) begin
                                ram_write_enable <= 1'b1;
                                ram_index        <= pe_operand_1[IDX_W-1:0];
                                ram_write_data   <= pe_operand_0;
                            end
                        end
                        default: ;
                    endcase
                    if (grant != OWN_NONE) state <= ISSUE;
                    if (!pe_req || grant == OWN_PE)
                        streak <= '0;
                    else if (grant != OWN_NONE && streak != STREAK_W'(MAX_HOST_STREAK))
                        streak <= streak + 1'b1;
                end
                ISSUE: begin
                    ram_read_enable  <= 1'b0;
                    ram_write_enable <= 1'b0;
                    ram_index        <= '0;
                    ram_write_data   <= '0;
                    state            <= COMPLETE;
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Acks are decoded from registered state; RAM read data is valid exactly in COMPLETE.
    always_comb begin
        host_interface.read_ack  = (state == COMPLETE) && (owner == OWN_HOST_RD);
        host_interface.write_ack = (state == COMPLETE) && (owner == OWN_HOST_WR);
        host_interface.read_data = host_interface.read_ack ? ram_read_data : '0;
        pe_result_valid          = (state == COMPLETE) && (owner == OWN_PE);
        pe_result                = (pe_result_valid && pe_is_lsw) ? ram_read_data : '0;
        pe_stall                 = pe_req && !pe_result_valid;
    end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Scoreboard bench for scratchpad_arbiter: drivers push the expected ack
// (kind + data) when they issue a request; the monitor pops and compares
// whenever an ack or pe_result_valid appears. A behavioural RAM closes the loop.
module tb_scratchpad_arbiter;
    localparam logic [5:0] LSW = 6'h10;
    localparam logic [5:0] SSW = 6'h11;
    localparam logic [5:0] ADD = 6'h01;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pe_req = 1'b0;
    logic [5:0]  pe_op = '0;
    logic [31:0] op0 = '0, op1 = '0;
    logic        pe_stall, pe_result_valid;
    logic [31:0] pe_result;
    logic        ram_read_enable, ram_write_enable;
    logic [9:0]  ram_index;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data = '0;

    always #5 clock = ~clock;

    mmio_if #(.ADDR_W(32), .DATA_W(32)) host ();

    scratchpad_arbiter #(
        .DEPTH(1024), .MAX_HOST_STREAK(4), .TIA_WORD_WIDTH(32), .TIA_OP_WIDTH(6),
        .OP_LSW(LSW), .OP_SSW(SSW)
    ) dut (
        .clock(clock), .reset(reset), .host_interface(host),
        .pe_req(pe_req), .pe_op(pe_op), .pe_operand_0(op0), .pe_operand_1(op1),
        .pe_stall(pe_stall), .pe_result(pe_result), .pe_result_valid(pe_result_valid),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .ram_index(ram_index), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
    );

    // Single-port RAM model, one-cycle read latency
    logic [31:0] mem [0:1023];
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_index] <= ram_write_data;
        if (ram_read_enable)  ram_read_data  <= mem[ram_index];
    end

    typedef struct { int kind; logic [31:0] data; } exp_t;  // kind: 0 read, 1 write, 2 pe
    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_exp(input int k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every ack against the head of the scoreboard
    always @(negedge clock) begin : monitor
        int n;
        int k;
        logic [31:0] d;
        exp_t e;
        if (reset) begin
            n = int'(host.read_ack) + int'(host.write_ack) + int'(pe_result_valid);
            if (n > 1) check("ack_onehot", n, 1);
            if (n == 1) begin
                k = host.read_ack ? 0 : (host.write_ack ? 1 : 2);
                d = (k == 0) ? host.read_data : ((k == 2) ? pe_result : 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack kind=%0d data=%h required=none", k, d);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_kind", k, e.kind);
                    check("ack_data", d, e.data);
                end
            end else begin
                if (host.read_data !== 32'h0) check("read_data_idle", host.read_data, 0);
                if (pe_result !== 32'h0)      check("pe_result_idle", pe_result, 0);
            end
        end
    end

    // Wait (bounded) for an ack; the first negedge after driving is cycle N.
    task automatic wait_ack(input int which, input int lat, input string name);
        int c;
        bit seen;
        seen = 0;
        for (c = 0; c < 40; c++) begin
            @(negedge clock);
            if ((which == 0 && host.read_ack) || (which == 1 && host.write_ack) ||
                (which == 2 && pe_result_valid)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=none required=ack", name);
        end else if (lat >= 0) begin
            check(name, c, lat);
        end
    endtask

    task automatic host_op(input bit rd, input int idx, input logic [31:0] data,
                           input logic [31:0] exp_rd, input int lat);
        push_exp(rd ? 0 : 1, rd ? exp_rd : 32'h0);
        @(posedge clock); #1;
        if (rd) begin
            host.read_req = 1'b1; host.read_index = idx;
        end else begin
            host.write_req = 1'b1; host.write_index = idx; host.write_data = data;
        end
        wait_ack(rd ? 0 : 1, lat, rd ? "host_read_lat" : "host_write_lat");
        @(posedge clock); #1;
        host.read_req = 1'b0;
        host.write_req = 1'b0;
    endtask

    task automatic pe_do(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit exp_re, input bit exp_we,
                         input int exp_idx);
        push_exp(2, exp_res);
        @(posedge clock); #1;
        pe_req = 1'b1; pe_op = op; op0 = a; op1 = b;
        @(negedge clock);
        check("pe_stall_c0", pe_stall, 1);
        @(negedge clock);
        check("pe_stall_c1", pe_stall, 1);
        check("pe_ram_re", ram_read_enable, exp_re);
        check("pe_ram_we", ram_write_enable, exp_we);
        if (exp_re || exp_we) check("pe_ram_idx", ram_index, exp_idx);
        @(negedge clock);
        check("pe_valid_c2", pe_result_valid, 1);
        check("pe_stall_c2", pe_stall, 0);
        @(posedge clock); #1;
        pe_req = 1'b0;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        host.read_req = 0; host.read_index = 0;
        host.write_req = 0; host.write_index = 0; host.write_data = 0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_ram_ctrl", {ram_read_enable, ram_write_enable, ram_index, ram_write_data}, 0);
        check("rst_acks", {host.read_ack, host.write_ack, pe_result_valid}, 0);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        check("idle_ram_ctrl", {ram_read_enable, ram_write_enable, ram_index}, 0);
        check("idle_read_data", host.read_data, 0);

        // 1: host write then read
        host_op(0, 5, 32'hDEAD, 0, 2);
        host_op(1, 5, 0, 32'hDEAD, 2);

        // 2: PE SSW then LSW
        pe_do(SSW, 32'h1234, 7, 32'h0, 0, 1, 7);
        pe_do(LSW, 7, 0, 32'h1234, 1, 0, 7);

        // 3: host streak vs held pe_req: 4 host acks, PE, then host resumes
        for (int i = 0; i < 4; i++) push_exp(1, 0);
        push_exp(2, 0);
        push_exp(1, 0);
        push_exp(1, 0);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(posedge clock); #1;
                    host.write_req = 1'b1; host.write_index = 40 + i; host.write_data = 32'h100 + i;
                    wait_ack(1, -1, "streak_host");
                end
                @(posedge clock); #1 host.write_req = 1'b0;
            end
            begin
                @(posedge clock); #1;
                pe_req = 1'b1; pe_op = SSW; op0 = 32'hAAAA; op1 = 30;
                wait_ack(2, 14, "streak_pe_lat");
                @(posedge clock); #1 pe_req = 1'b0;
            end
        join
        host_op(1, 43, 0, 32'h103, 2);
        pe_do(LSW, 30, 0, 32'hAAAA, 1, 0, 30);

        // 4: simultaneous read+write to same index
        host_op(0, 3, 32'h1, 0, 2);
        push_exp(0, 32'h1);
        push_exp(1, 0);
        @(posedge clock); #1;
        host.read_req = 1; host.read_index = 3;
        host.write_req = 1; host.write_index = 3; host.write_data = 32'hBEEF;
        wait_ack(0, 2, "rw_read_lat");
        @(posedge clock); #1 host.read_req = 0;
        wait_ack(1, 2, "rw_write_gap");
        @(posedge clock); #1 host.write_req = 0;
        host_op(1, 3, 0, 32'hBEEF, 2);

        // 5: reset during ISSUE of a host write
        @(posedge clock); #1;
        host.write_req = 1; host.write_index = 20; host.write_data = 32'h5555;
        @(posedge clock); #1;
        check("rst_issue_we", ram_write_enable, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_ram", {ram_read_enable, ram_write_enable, ram_index, ram_write_data}, 0);
        check("rst_mid_acks", {host.read_ack, host.write_ack, pe_result_valid}, 0);
        check("rst_mid_data", host.read_data | pe_result, 0);
        host.write_req = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        host_op(1, 20, 0, 32'h0, 2);

        // 6: PE index truncation and non-memory opcode
        host_op(0, 9, 32'h9999, 0, 2);
        pe_do(LSW, 32'h409, 0, 32'h9999, 1, 0, 9);
        pe_do(ADD, 32'h5, 32'h6, 32'h0, 0, 0, 0);

        repeat (4) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
